// File: rtl/pixel_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_word_packer
//  Purpose  : Packs an 8-bit pixel stream (Valid/Data/Last) little-endian into
//             BYTES_PER_WORD-byte AXI4-Stream words. Completed words are queued
//             in a small FIFO for the DMA write channel. Short final words are
//             marked with TKEEP. A sticky flag records pixels that were dropped.
//  Ports    : Clk, rst (async, active-low)
//             Valid_in/Data_in/Last_in  pixel input; Ready_out accept indicator
//             Valid_out/Data_out/Keep_out/Last_out/Ready_from_dma  AXIS output
//             Overflow (sticky drop flag), Ovf_clr (synchronous clear)
//  Revision : 1.0  initial release
// ============================================================================
module pixel_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        Clk,
    input  logic                        rst,
    input  logic                        Valid_in,
    input  logic [7:0]                  Data_in,
    input  logic                        Last_in,
    output logic                        Ready_out,
    output logic                        Valid_out,
    output logic [8*BYTES_PER_WORD-1:0] Data_out,
    output logic [BYTES_PER_WORD-1:0]   Keep_out,
    output logic                        Last_out,
    input  logic                        Ready_from_dma,
    output logic                        Overflow,
    input  logic                        Ovf_clr
);

    localparam int C_DW = 8 * BYTES_PER_WORD;
    localparam int C_CW = $clog2(BYTES_PER_WORD);
    localparam int C_PW = $clog2(FIFO_DEPTH);

    localparam logic [C_CW-1:0] C_LAST_LANE = C_CW'(BYTES_PER_WORD - 1);
    localparam logic [C_PW:0]   C_FULL      = (C_PW + 1)'(FIFO_DEPTH);

    // Packing state
    logic [C_CW-1:0]           cnt_q, cnt_d;
    logic [C_DW-1:0]           acc_q, acc_d;

    // Word FIFO
    logic [C_DW-1:0]           mem_data_q [FIFO_DEPTH];
    logic [BYTES_PER_WORD-1:0] mem_keep_q [FIFO_DEPTH];
    logic                      mem_last_q [FIFO_DEPTH];
    logic [C_PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [C_PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [C_PW:0]             count_q, count_d;

    logic                      ovf_q, ovf_d;
    // Holds Ready_out low during reset and for the first cycle after release.
    logic                      rdy_en_q;

    logic                      fifo_full, fifo_empty;
    logic                      accept, drop, complete, push, pop;
    logic [C_DW-1:0]           new_word;
    logic [BYTES_PER_WORD-1:0] new_keep;

    always_comb begin
        fifo_full  = (count_q == C_FULL);
        fifo_empty = (count_q == '0);
        Ready_out  = rdy_en_q && !fifo_full;
        accept     = Valid_in && Ready_out;
        drop       = Valid_in && !Ready_out;

        // Merge the incoming pixel into its lane; keep covers lanes 0..cnt.
        new_word = acc_q;
        new_keep = '0;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            if (C_CW'(l) == cnt_q) begin
                new_word[8*l +: 8] = Data_in;
            end
            if (C_CW'(l) <= cnt_q) begin
                new_keep[l] = 1'b1;
            end
        end

        complete = accept && ((cnt_q == C_LAST_LANE) || Last_in);
        push     = complete;
        pop      = !fifo_empty && Ready_from_dma;

        cnt_d = cnt_q;
        acc_d = acc_q;
        if (complete) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = new_word;
        end

        // Pointers wrap naturally since FIFO_DEPTH is a power of two.
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new drop wins over a clear in the same cycle.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (Ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= new_word;
            mem_keep_q[wr_ptr_q] <= new_keep;
            mem_last_q[wr_ptr_q] <= Last_in;
        end
    end

    always_comb begin
        Valid_out = !fifo_empty;
        Data_out  = '0;
        Keep_out  = '0;
        Last_out  = 1'b0;
        if (!fifo_empty) begin
            Data_out = mem_data_q[rd_ptr_q];
            Keep_out = mem_keep_q[rd_ptr_q];
            Last_out = mem_last_q[rd_ptr_q];
        end
        Overflow = ovf_q;
    end

endmodule
`default_nettype wire
